fetch_sequencer: RTL and testbench

- Run-control and PC-steering controller for the instruction-fetch stage of the UART-debugged MIPS pipeline.
- Takes run/step/stop commands from the UART command decoder, plus hazard and redirect requests from the decode and execute stages.
- Drives the fetch stage's PC_write, PC_sel, jump_sel and pipeline enable/flush controls.
- Detects a HALT instruction, drains the pipeline and reports completion back to the UART side.

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_sequencer_redirect_ctrl.sv | 55 +++++
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch-stage run-control slice.
//   fsm_state_e : run-control FSM states (3-bit encoding)
//   pc_sel_e    : PC mux select, packed as {PC_sel, jump_sel}
//   HALT_OPCODE : default opcode (instruc[31:26]) that stops execution
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } fsm_state_e;

  typedef enum logic [1:0] {
    SEL_PC1 = 2'b00,
    SEL_JMP = 2'b01,
    SEL_BR  = 2'b10
  } pc_sel_e;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/fetch_sequencer_redirect_ctrl.sv
// Combinational redirect priority for the fetch stage.
// Ports:
//   pipe_enable     in  pipeline currently advancing
//   stall           in  load-use stall
//   halt_hold       in  HALT seen this cycle or draining
//   branch_taken_ex in  branch resolved taken in EX (oldest, highest priority)
//   jump_id         in  jump decoded in ID
//   PC_write        out PC load enable
//   PC_sel          out select branch target
//   jump_sel        out select jump target
//   if_id_flush     out bubble IF/ID
//   id_ex_flush     out bubble ID/EX
module redirect_ctrl
  import fetch_sequencer_pkg::*;
(
  input  logic pipe_enable,
  input  logic stall,
  input  logic halt_hold,
  input  logic branch_taken_ex,
  input  logic jump_id,
  output logic PC_write,
  output logic PC_sel,
  output logic jump_sel,
  output logic if_id_flush,
  output logic id_ex_flush
);

  pc_sel_e sel;

  always_comb begin
    sel         = SEL_PC1;
    PC_write    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (pipe_enable) begin
      if (branch_taken_ex) begin
        // A taken branch overrides stall and any pending halt: the younger
        // instructions (including a HALT) are on the wrong path.
        sel         = SEL_BR;
        PC_write    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        if (jump_id && !stall && !halt_hold) begin
          sel         = SEL_JMP;
          if_id_flush = 1'b1;
        end
        PC_write = !stall && !halt_hold;
      end
    end
  end

  assign {PC_sel, jump_sel} = sel;

endmodule

// File: rtl/fetch_sequencer.sv
// Run-control and PC-steering controller for the instruction-fetch stage.
// Ports:
//   clock, reset_n                  clock and synchronous active-low reset
//   cmd_run/cmd_step/cmd_stop       one-cycle command pulses (stop > step > run)
//   stall, jump_id, branch_taken_ex hazard and redirect requests
//   opcode_id                       opcode of the instruction in ID
//   pipe_enable, PC_write           pipeline / PC enables
//   PC_sel, jump_sel                PC mux select (10 branch, 01 jump, 00 PC+1)
//   if_id_flush, id_ex_flush        pipeline bubbles
//   done                            pulse in the final drain cycle
//   running                         high in RUN, STEP or DRAIN
//   cycle_count                     saturating count of enabled cycles
module fetch_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16,
  parameter logic [5:0]  HALT_OPCODE  = fetch_sequencer_pkg::HALT_OPCODE
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_stop,
  input  logic             stall,
  input  logic             jump_id,
  input  logic             branch_taken_ex,
  input  logic [5:0]       opcode_id,
  output logic             pipe_enable,
  output logic             PC_write,
  output logic             PC_sel,
  output logic             jump_sel,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             done,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count
);

  import fetch_sequencer_pkg::*;

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  fsm_state_e       state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic halt_seen;
  logic halt_hold;

  assign pipe_enable = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
  assign running     = pipe_enable;
  assign halt_seen   = (opcode_id == HALT_OPCODE) && pipe_enable && !stall;
  assign halt_hold   = (state_q == ST_DRAIN) || halt_seen;

  redirect_ctrl u_redirect_ctrl (
    .pipe_enable     (pipe_enable),
    .stall           (stall),
    .halt_hold       (halt_hold),
    .branch_taken_ex (branch_taken_ex),
    .jump_id         (jump_id),
    .PC_write        (PC_write),
    .PC_sel          (PC_sel),
    .jump_sel        (jump_sel),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush)
  );

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    cycle_count_d = cycle_count_q;

    if (pipe_enable && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_stop) begin
          state_d = ST_IDLE;
        end else if (cmd_step) begin
          state_d = ST_STEP;
        end else if (cmd_run) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cmd_stop) begin
          state_d = ST_IDLE;
        end else if (halt_seen) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      ST_STEP: begin
        if (halt_seen) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (branch_taken_ex) begin
          state_d = ST_RUN;
        end else if (drain_cnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      ST_HALTED: begin
        if (cmd_run && !cmd_stop && !cmd_step) begin
          state_d       = ST_RUN;
          cycle_count_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // done is registered, so it is computed from the next state: it lands in
    // the last drain cycle, i.e. the cycle that transitions into HALTED.
    done_d = (state_d == ST_DRAIN) && (drain_cnt_d == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      drain_cnt_q   <= '0;
      done_q        <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      done_q        <= done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign done        = done_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clock;
  logic        reset_n;
  logic        cmd_run, cmd_step, cmd_stop;
  logic        stall, jump_id, branch_taken_ex;
  logic [5:0]  opcode_id;
  logic        pipe_enable, PC_write, PC_sel, jump_sel;
  logic        if_id_flush, id_ex_flush, done, running;
  logic [15:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_done;

  fetch_sequencer #(
    .DRAIN_CYCLES (4),
    .CNT_W        (16),
    .HALT_OPCODE  (6'b111111)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cmd_run         (cmd_run),
    .cmd_step        (cmd_step),
    .cmd_stop        (cmd_stop),
    .stall           (stall),
    .jump_id         (jump_id),
    .branch_taken_ex (branch_taken_ex),
    .opcode_id       (opcode_id),
    .pipe_enable     (pipe_enable),
    .PC_write        (PC_write),
    .PC_sel          (PC_sel),
    .jump_sel        (jump_sel),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .done            (done),
    .running         (running),
    .cycle_count     (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".pe"},   32'(pipe_enable), 0);
    check_eq({tag, ".pcw"},  32'(PC_write), 0);
    check_eq({tag, ".sel"},  32'({PC_sel, jump_sel}), 0);
    check_eq({tag, ".fl"},   32'({if_id_flush, id_ex_flush}), 0);
    check_eq({tag, ".done"}, 32'(done), 0);
    check_eq({tag, ".run"},  32'(running), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; cmd_run = 0; cmd_step = 0; cmd_stop = 0;
    stall = 0; jump_id = 0; branch_taken_ex = 0; opcode_id = '0;

    // Reset then idle
    repeat (3) tick();
    settle();
    check_all_zero("rst");
    check_eq("rst.cnt", 32'(cycle_count), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); settle();
      check_all_zero("idle");
      check_eq("idle.cnt", 32'(cycle_count), 0);
    end

    // Single steps: one enabled cycle each
    for (int s = 1; s <= 3; s++) begin
      cmd_step = 1; tick(); cmd_step = 0; settle();
      check_eq("step.pe",  32'(pipe_enable), 1);
      check_eq("step.pcw", 32'(PC_write), 1);
      check_eq("step.cnt_during", 32'(cycle_count), 32'(s - 1));
      tick(); settle();
      check_eq("step.pe_after", 32'(pipe_enable), 0);
      check_eq("step.cnt", 32'(cycle_count), 32'(s));
    end

    // Run for 20 cycles then stop
    do_reset();
    cmd_run = 1; tick(); cmd_run = 0;
    repeat (19) tick();
    settle();
    check_eq("run.cnt19", 32'(cycle_count), 19);
    check_eq("run.pcw", 32'(PC_write), 1);
    cmd_stop = 1; tick(); cmd_stop = 0; settle();
    check_eq("stop.run", 32'(running), 0);
    check_eq("stop.cnt", 32'(cycle_count), 20);
    tick(); settle();
    check_eq("stop.cnt_hold", 32'(cycle_count), 20);
    cmd_run = 1; cmd_stop = 1; tick(); cmd_run = 0; cmd_stop = 0; settle();
    check_eq("runstop.run", 32'(running), 0);
    check_eq("runstop.cnt", 32'(cycle_count), 20);

    // HALT drain: HALT in ID in run cycle 5
    do_reset();
    cmd_run = 1; tick(); cmd_run = 0;   // cycle 1
    repeat (4) tick();                  // cycle 5
    opcode_id = 6'h3F; settle();
    check_eq("halt.pcw5", 32'(PC_write), 0);
    check_eq("halt.pe5",  32'(pipe_enable), 1);
    n_done = 0;
    for (int c = 6; c <= 9; c++) begin
      tick(); opcode_id = '0; settle();
      check_eq("drain.pe",  32'(pipe_enable), 1);
      check_eq("drain.pcw", 32'(PC_write), 0);
      check_eq("drain.done", 32'(done), (c == 9) ? 1 : 0);
      if (done) n_done++;
    end
    tick(); settle();
    check_all_zero("halted");
    check_eq("halted.cnt", 32'(cycle_count), 9);
    check_eq("halt.done_once", 32'(n_done), 1);
    cmd_step = 1; tick(); cmd_step = 0; settle();
    check_eq("halted.step_ign", 32'(running), 0);
    check_eq("halted.step_cnt", 32'(cycle_count), 9);
    cmd_run = 1; tick(); cmd_run = 0; settle();
    check_eq("restart.run", 32'(running), 1);
    check_eq("restart.cnt", 32'(cycle_count), 0);
    tick(); settle();
    check_eq("restart.cnt1", 32'(cycle_count), 1);

    // Redirect priority (in RUN)
    branch_taken_ex = 1; jump_id = 1; settle();
    check_eq("br+j.sel", 32'({PC_sel, jump_sel}), 32'b10);
    check_eq("br+j.fl",  32'({if_id_flush, id_ex_flush}), 32'b11);
    check_eq("br+j.pcw", 32'(PC_write), 1);
    branch_taken_ex = 0; settle();
    check_eq("j.sel", 32'({PC_sel, jump_sel}), 32'b01);
    check_eq("j.fl",  32'({if_id_flush, id_ex_flush}), 32'b10);
    check_eq("j.pcw", 32'(PC_write), 1);
    stall = 1; settle();
    check_eq("j+st.sel", 32'({PC_sel, jump_sel}), 32'b00);
    check_eq("j+st.fl",  32'({if_id_flush, id_ex_flush}), 32'b00);
    check_eq("j+st.pcw", 32'(PC_write), 0);
    jump_id = 0; branch_taken_ex = 1; settle();
    check_eq("br+st.sel", 32'({PC_sel, jump_sel}), 32'b10);
    check_eq("br+st.pcw", 32'(PC_write), 1);
    branch_taken_ex = 0; stall = 0;

    // Wrong-path halt: branch during DRAIN returns to RUN
    opcode_id = 6'h3F; tick(); opcode_id = '0;   // DRAIN, cnt 3
    settle();
    check_eq("wp.drain_pcw", 32'(PC_write), 0);
    jump_id = 1; settle();
    check_eq("wp.jmp_ign_sel", 32'({PC_sel, jump_sel}), 32'b00);
    check_eq("wp.jmp_ign_fl",  32'(if_id_flush), 0);
    jump_id = 0;
    tick();                                      // DRAIN, cnt 2
    branch_taken_ex = 1; settle();
    check_eq("wp.br_pcw", 32'(PC_write), 1);
    check_eq("wp.br_sel", 32'({PC_sel, jump_sel}), 32'b10);
    tick(); branch_taken_ex = 0; settle();
    check_eq("wp.rerun_pcw", 32'(PC_write), 1);
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); settle();
      if (done) n_done++;
    end
    check_eq("wp.still_run", 32'(running), 1);
    check_eq("wp.no_done", 32'(n_done), 0);

    // Reset in the middle of DRAIN
    opcode_id = 6'h3F; tick(); opcode_id = '0;   // DRAIN, cnt 3
    tick();                                      // DRAIN, cnt 2
    settle();
    check_eq("rd.in_drain", 32'(running), 1);
    reset_n = 0; tick(); reset_n = 1; settle();
    check_all_zero("rd.after");
    check_eq("rd.cnt", 32'(cycle_count), 0);
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      if (done || running) n_done++;
    end
    check_eq("rd.quiet", 32'(n_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
